// File: rtl/logicnets_lut_layer.sv
// logicnets_lut_layer: layer of independent LUT neurons with a one-deep valid/ready output register.
// Define LOGICNETS_LUT_READBACK_EN to add the cfg_re/cfg_rdata table readback port.
module logicnets_lut_layer #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 1,
  parameter int NEURONS  = 4,
  localparam int NW = NEURONS > 1 ? $clog2(NEURONS) : 1
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NEURONS*IN_BITS-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NEURONS*OUT_BITS-1:0]  out_data,
  input  logic                         cfg_we,
  input  logic [NW-1:0]                cfg_neuron,
  input  logic [IN_BITS-1:0]           cfg_addr,
  input  logic [OUT_BITS-1:0]          cfg_data
`ifdef LOGICNETS_LUT_READBACK_EN
  ,
  input  logic                         cfg_re,
  output logic [OUT_BITS-1:0]          cfg_rdata
`endif
);
  localparam int DEPTH = 2**IN_BITS;
  logic [OUT_BITS-1:0]         r_tab [NEURONS][DEPTH];
  logic                        r_valid;
  logic [NEURONS*OUT_BITS-1:0] r_data;
  logic [NEURONS*OUT_BITS-1:0] w_lut;
  logic                        w_hit;
  logic                        w_xfer;
  assign w_hit     = 32'(cfg_neuron) < NEURONS;
  assign in_ready  = (!r_valid || out_ready) && !cfg_we && !rst;
  assign w_xfer    = in_valid && in_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  for (genvar n = 0; n < NEURONS; n++) begin : g_lut
    assign w_lut[n*OUT_BITS +: OUT_BITS] = r_tab[n][in_data[n*IN_BITS +: IN_BITS]];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NEURONS; n++)
        for (int a = 0; a < DEPTH; a++)
          r_tab[n][a] <= '0;
    end else if (cfg_we && w_hit) begin
      r_tab[cfg_neuron][cfg_addr] <= cfg_data;
    end
  end
  // out_data only loads on a transfer so it keeps its last result while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_lut;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end
`ifdef LOGICNETS_LUT_READBACK_EN
  logic [OUT_BITS-1:0] r_rdata;
  assign cfg_rdata = r_rdata;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rdata <= '0;
    else if (cfg_re) r_rdata <= w_hit ? r_tab[cfg_neuron][cfg_addr] : '0;
  end
`endif
endmodule

// File: tb/tb_logicnets_lut_layer.sv
// tb_logicnets_lut_layer: random and directed traffic against a table/queue reference model.
module tb_logicnets_lut_layer;
  localparam int N = 4, IB = 6, OB = 1;
  logic          clk = 1'b0, rst = 1'b1;
  logic          in_valid = 1'b0, out_ready = 1'b0, cfg_we = 1'b0;
  logic          in_ready, out_valid;
  logic [N*IB-1:0] in_data = '0;
  logic [N*OB-1:0] out_data;
  logic [1:0]    cfg_neuron = '0;
  logic [IB-1:0] cfg_addr = '0;
  logic [OB-1:0] cfg_data = '0;
`ifdef LOGICNETS_LUT_READBACK_EN
  logic          cfg_re = 1'b0;
  logic [OB-1:0] cfg_rdata;
`endif
  int checks = 0, errors = 0;
  bit tab [N][2**IB];
  logic [N*OB-1:0] q [$];
  logic [N*OB-1:0] first;
  int vcnt;

  logicnets_lut_layer #(.IN_BITS(IB), .OUT_BITS(OB), .NEURONS(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_neuron(cfg_neuron), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
`ifdef LOGICNETS_LUT_READBACK_EN
    , .cfg_re(cfg_re), .cfg_rdata(cfg_rdata)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N*OB-1:0] lut(input logic [N*IB-1:0] d);
    logic [N*OB-1:0] r;
    for (int n = 0; n < N; n++) r[n] = tab[n][d[n*IB +: IB]];
    return r;
  endfunction

  // one cycle: drive at negedge, model the posedge, check at the next negedge
  task automatic cyc(input logic v, input logic [N*IB-1:0] d, input logic ordy,
                     input logic we, input logic [1:0] nn, input logic [IB-1:0] a, input logic dd);
    logic exp_rdy;
    in_valid = v; in_data = d; out_ready = ordy;
    cfg_we = we; cfg_neuron = nn; cfg_addr = a; cfg_data = dd;
    exp_rdy = (q.size() == 0 || ordy) && !we;
    #1 chk("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    if (q.size() != 0 && ordy) void'(q.pop_front());
    if (v && exp_rdy) q.push_back(lut(d));
    if (we && nn < N) tab[nn][a] = dd;
    @(negedge clk);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) chk("out_data", out_data, q[0]);
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, '0, ordy, 1'b0, 2'd0, '0, 1'b0);
  endtask

  initial begin
    #1 chk("reset in_ready", in_ready, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    @(negedge clk); rst = 1'b0;
    cyc(1'b1, 24'h3F3F3F, 1'b1, 1'b0, 2'd0, '0, 1'b0);
    chk("cleared tables", out_data, 0);
    cyc(1'b0, '0, 1'b1, 1'b1, 2'd2, 6'b001001, 1'b1);
    cyc(1'b1, 24'(6'b001001) << 12, 1'b1, 1'b0, 2'd0, '0, 1'b0);
    chk("neuron2 write", out_data, 4'b0100);
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 24'($urandom), 1'b1, 1'b0, 2'd0, '0, 1'b0);
      vcnt += int'(out_valid);
    end
    chk("b2b valid count", vcnt, 8);
    first = q[0];
    for (int i = 0; i < 3; i++) cyc(1'b1, 24'h009000, 1'b0, 1'b0, 2'd0, '0, 1'b0);
    chk("stall stable", out_data, first);
    cyc(1'b1, 24'h009000, 1'b1, 1'b0, 2'd0, '0, 1'b0);
    chk("stalled input delivered", out_data, 4'b0100);
    cyc(1'b1, 24'h000001, 1'b1, 1'b1, 2'd0, 6'd1, 1'b1);
    cyc(1'b1, 24'h000001, 1'b1, 1'b0, 2'd0, '0, 1'b0);
    chk("cfg then transfer", out_data, 4'b0001);
    for (int i = 0; i < 400; i++) begin
      logic [N*IB-1:0] d;
      for (int n = 0; n < N; n++) d[n*IB +: IB] = 6'($urandom_range(0, 7));
      cyc(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 7) == 0), 2'($urandom), 6'($urandom_range(0, 7)), 1'($urandom));
    end
    cyc(1'b1, 24'h009000, 1'b0, 1'b0, 2'd0, '0, 1'b0);
    chk("pre-reset valid", out_valid, 1);
    rst = 1'b1;
    #1 chk("async clear valid", out_valid, 0);
    chk("reset in_ready low", in_ready, 0);
    q.delete();
    foreach (tab[n, a]) tab[n][a] = 1'b0;
    @(negedge clk); rst = 1'b0;
    cyc(1'b1, 24'h009041, 1'b1, 1'b0, 2'd0, '0, 1'b0);
    chk("table zero after reset", out_data, 0);
`ifdef LOGICNETS_LUT_READBACK_EN
    cfg_re = 1'b1; cfg_neuron = 2'd2; cfg_addr = 6'b001001;
    @(posedge clk); @(negedge clk);
    cfg_re = 1'b0;
    chk("readback zero", cfg_rdata, 0);
`endif
    idle(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
